// File: rtl/hacd_pkg.sv
// Shared HAWK chipset definitions: AXI read packets, constants,
// and block alignment helper.
package hacd_pkg;

  localparam int BLK_SIZE = 64;
  localparam logic [2:0] AXI_SIZE_64B = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int HAWK_RD_MAX_OUTSTANDING = 4;

  typedef enum logic {
    AR_IDLE,
    AR_ADDR
  } ar_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [47:0] tag;
    logic        arvalid;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic [511:0] data;
    logic [47:0]  tag;
    logic         err;
    logic         rvalid;
  } axi_rd_resppkt_t;

  function automatic logic [63:0] blk_align(input logic [63:0] a);
    blk_align = a & ~64'(BLK_SIZE - 1);
  endfunction

endpackage

// File: rtl/hawk_rd_tag_fifo.sv
// Tag FIFO for in-flight reads; occupancy counter separates
// full from empty since pointers wrap naturally.
module hawk_rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic push_ok;
  logic pop_ok;

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/hawk_axi_rd_master.sv
// HAWK 64B block AXI4 read master, in-order, one-entry resp skid.
// Optional watchdog enabled by defining HAWK_RD_TIMEOUT_EN.
module hawk_axi_rd_master
  import hacd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = HAWK_RD_MAX_OUTSTANDING,
  parameter int AXI_ID = 0,
  parameter int TAG_W = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      req_addr,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [511:0]     resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [3:0]       m_axi_arid,
  output logic [63:0]      m_axi_araddr,
  output logic [7:0]       m_axi_arlen,
  output logic [2:0]       m_axi_arsize,
  output logic [1:0]       m_axi_arburst,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [3:0]       m_axi_rid,
  input  logic [511:0]     m_axi_rdata,
  input  logic [1:0]       m_axi_rresp,
  input  logic             m_axi_rlast,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  ar_state_e        state_q;
  ar_state_e        state_d;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      addr_q;
  logic             skid_q;
  logic [511:0]     data_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] fifo_tag;
  logic             req_ok;
  logic             ar_go;
  logic             req_hs;
  logic             ar_hs;
  logic             r_hs;

  assign m_axi_arid    = 4'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_64B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = ar_go;
  assign req_ready     = req_ok;

  always_comb begin
    state_d = state_q;
    req_ok  = 1'b0;
    ar_go   = 1'b0;
    unique case (state_q)
      AR_IDLE: begin
        req_ok = !rst && !fifo_full &&
                 (count_q < CNT_W'(MAX_OUTSTANDING));
        if (req_valid && req_ok) state_d = AR_ADDR;
      end
      AR_ADDR: begin
        ar_go = 1'b1;
        if (m_axi_arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign req_hs = req_valid && req_ok;
  assign ar_hs  = ar_go && m_axi_arready;
  // Beats with nothing outstanding are protocol violations; never accept.
  assign m_axi_rready = (count_q != '0) && (!skid_q || resp_ready);
  assign r_hs = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AR_IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) addr_q <= blk_align(req_addr);
      unique case ({ar_hs, r_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else if (r_hs) begin
      skid_q <= 1'b1;
      data_q <= m_axi_rdata;
      tag_q  <= fifo_tag;
      err_q  <= (m_axi_rresp != 2'b00) || !m_axi_rlast;
    end else if (resp_ready) begin
      skid_q <= 1'b0;
    end
  end

  assign resp_valid = skid_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;

  hawk_rd_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(TAG_W)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_hs),
    .pop  (r_hs),
    .wdata(req_tag),
    .rdata(fifo_tag),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef HAWK_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            to_q;

  // Saturates at the limit; the flag stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (count_q == '0 || r_hs) begin
      wd_q <= '0;
    end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
      wd_q <= wd_q + 1'b1;
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) to_q <= 1'b1;
    end
  end

  assign timeout_err = to_q;
`else
  logic unused_to;
  assign unused_to   = TIMEOUT_CYCLES[0];
  assign timeout_err = 1'b0;
`endif

  logic unused;
  assign unused = ^{m_axi_rid, req_addr[5:0], fifo_empty};

endmodule

// File: tb/tb_hawk_axi_rd_master.sv
// Bench for hawk_axi_rd_master: queue model checked every cycle
// plus directed literal checks.
module tb_hawk_axi_rd_master;

  localparam int MAXO = 4;
  localparam int TO = 16;
`ifdef HAWK_RD_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [63:0]  req_addr;
  logic [47:0]  req_tag;
  logic         req_valid;
  logic         req_ready;
  logic [511:0] resp_data;
  logic [47:0]  resp_tag;
  logic         resp_err;
  logic         resp_valid;
  logic         resp_ready;
  logic [3:0]   m_axi_arid;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [3:0]   m_axi_rid;
  logic [511:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic         timeout_err;

  hawk_axi_rd_master #(
    .MAX_OUTSTANDING(MAXO),
    .AXI_ID(0),
    .TAG_W(48),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_tag(req_tag),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_err(resp_err), .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [511:0] d;
    logic [47:0]  t;
    logic         e;
  } rsp_t;

  rsp_t        rq[$];
  logic [47:0] tq[$];
  logic [47:0] seen[$];
  rsp_t        nr;
  bit          ar_pend;
  logic [63:0] ar_addr;
  int          outst;
  int          wd;
  bit          exp_to;
  bit          m_req, m_ar, m_r, m_rsp;

  // Model: one AR in flight at most, outst<=MAXO, one resp held.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_timeout", timeout_err, 0);
      rq.delete();
      tq.delete();
      ar_pend = 0;
      outst = 0;
      wd = 0;
      exp_to = 0;
    end else begin
      chk("req_ready", req_ready, !ar_pend && outst < MAXO);
      chk("arvalid", m_axi_arvalid, ar_pend);
      if (ar_pend) begin
        chk("araddr", m_axi_araddr, ar_addr);
        chk("arlen", m_axi_arlen, 0);
        chk("arsize", m_axi_arsize, 6);
        chk("arburst", m_axi_arburst, 1);
        chk("arid", m_axi_arid, 0);
      end
      chk("rready", m_axi_rready,
          outst > 0 && (rq.size() == 0 || resp_ready));
      chk("resp_valid", resp_valid, rq.size() > 0);
      if (rq.size() > 0) begin
        chk("resp_data", resp_data, rq[0].d);
        chk("resp_tag", resp_tag, rq[0].t);
        chk("resp_err", resp_err, rq[0].e);
      end
      chk("timeout_err", timeout_err, exp_to);

      m_rsp = rq.size() > 0 && resp_ready;
      m_r   = m_axi_rvalid && outst > 0 &&
              (rq.size() == 0 || resp_ready);
      m_ar  = ar_pend && m_axi_arready;
      m_req = !ar_pend && outst < MAXO && req_valid;

      if (TO_ON) begin
        if (outst > 0 && !m_r) begin
          if (wd < TO) wd++;
          if (wd == TO) exp_to = 1;
        end else begin
          wd = 0;
        end
      end
      if (m_rsp) begin
        seen.push_back(rq[0].t);
        void'(rq.pop_front());
      end
      if (m_r) begin
        nr.d = m_axi_rdata;
        nr.t = tq.pop_front();
        nr.e = (m_axi_rresp != 2'b00) || !m_axi_rlast;
        rq.push_back(nr);
        outst--;
      end
      if (m_ar) begin
        outst++;
        ar_pend = 0;
      end
      if (m_req) begin
        ar_pend = 1;
        ar_addr = {req_addr[63:6], 6'b0};
        tq.push_back(req_tag);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [63:0] a, input logic [47:0] t);
    bit ok;
    ok = 0;
    req_addr = a;
    req_tag = t;
    req_valid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_wait: got no req_ready expected accept");
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic r_beat(input logic [511:0] d, input logic [1:0] rr,
                        input logic last);
    bit ok;
    ok = 0;
    m_axi_rdata = d;
    m_axi_rresp = rr;
    m_axi_rlast = last;
    m_axi_rvalid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_axi_rready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL r_wait: got no rready expected accept");
    end
    @(posedge clk);
    #1;
    m_axi_rvalid = 0;
  endtask

  logic [511:0] a5;
  logic [511:0] pat;

  initial begin
    rst = 1;
    req_addr = '0;
    req_tag = '0;
    req_valid = 0;
    resp_ready = 1;
    m_axi_arready = 0;
    m_axi_rid = 4'h5;
    m_axi_rdata = '0;
    m_axi_rresp = 0;
    m_axi_rlast = 1;
    m_axi_rvalid = 0;
    a5 = {64{8'hA5}};
    step(3);
    chk("lit_rst_araddr", m_axi_araddr, 0);
    chk("lit_rst_data", resp_data, 0);
    rst = 0;
    step(1);

    // single read
    m_axi_arready = 1;
    do_req(64'hFF_F610_003F, 48'h1234);
    chk("lit_arvalid", m_axi_arvalid, 1);
    chk("lit_araddr", m_axi_araddr, 64'hFF_F610_0000);
    chk("lit_arsize", m_axi_arsize, 3'd6);
    step(1);
    r_beat(a5, 2'b00, 1);
    chk("lit_rvalid", resp_valid, 1);
    chk("lit_rdata", resp_data, a5);
    chk("lit_rtag", resp_tag, 48'h1234);
    chk("lit_rerr", resp_err, 0);
    step(2);

    // stray beat with nothing outstanding
    m_axi_rvalid = 1;
    step(3);
    chk("lit_stray_rready", m_axi_rready, 0);
    m_axi_rvalid = 0;
    step(1);

    // back-pressure and saturation
    m_axi_arready = 0;
    fork
      for (int i = 0; i < 5; i++)
        do_req(64'h4000 + 64'(i) * 64, 48'(100 + i));
      begin
        step(8);
        chk("lit_bp_arvalid", m_axi_arvalid, 1);
        chk("lit_bp_req_ready", req_ready, 0);
        m_axi_arready = 1;
        step(20);
        chk("lit_sat_req_ready", req_ready, 0);
        chk("lit_sat_arvalid", m_axi_arvalid, 0);
        for (int i = 0; i < 5; i++) begin
          pat = {16{32'hBEEF_0000 + 32'(i)}};
          r_beat(pat, 2'b00, 1);
        end
      end
    join
    step(3);

    // ordering under toggling resp_ready
    seen.delete();
    for (int i = 1; i <= 4; i++)
      do_req(64'h8000 + 64'(i) * 64, 48'(i));
    fork
      repeat (30) begin
        @(posedge clk);
        #1;
        resp_ready = ~resp_ready;
      end
      for (int i = 0; i < 4; i++) begin
        pat = {8{64'hC0DE_0000_0000_0000 + 64'(i)}};
        r_beat(pat, 2'b00, 1);
      end
    join
    resp_ready = 1;
    step(4);
    chk("lit_ord_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk("lit_ord_tag", seen[i], 48'(i + 1));

    // error beats
    for (int i = 0; i < 3; i++)
      do_req(64'hC000 + 64'(i) * 64, 48'(10 + i));
    step(1);
    r_beat({16{32'h1111_1111}}, 2'b10, 1);
    chk("lit_err_slverr", resp_err, 1);
    r_beat({16{32'h2222_2222}}, 2'b00, 0);
    chk("lit_err_nolast", resp_err, 1);
    r_beat({16{32'h3333_3333}}, 2'b00, 1);
    chk("lit_err_good", resp_err, 0);
    chk("lit_err_tag", resp_tag, 48'd12);
    step(2);

    // reset mid-op
    resp_ready = 0;
    for (int i = 0; i < 4; i++)
      do_req(64'h1_0000 + 64'(i) * 64, 48'(20 + i));
    r_beat({16{32'h4444_4444}}, 2'b00, 1);
    chk("lit_mid_skid", resp_valid, 1);
    rst = 1;
    #1;
    chk("lit_ar_arvalid", m_axi_arvalid, 0);
    chk("lit_ar_araddr", m_axi_araddr, 0);
    chk("lit_ar_req_ready", req_ready, 0);
    chk("lit_ar_resp_valid", resp_valid, 0);
    chk("lit_ar_resp_data", resp_data, 0);
    chk("lit_ar_resp_tag", resp_tag, 0);
    chk("lit_ar_resp_err", resp_err, 0);
    chk("lit_ar_rready", m_axi_rready, 0);
    chk("lit_ar_timeout", timeout_err, 0);
    step(2);
    rst = 0;
    resp_ready = 1;
    step(1);
    do_req(64'h2_0040, 48'hABC);
    step(1);
    r_beat(a5, 2'b00, 1);
    chk("lit_post_tag", resp_tag, 48'hABC);
    chk("lit_post_data", resp_data, a5);
    step(2);

    // watchdog
    do_req(64'h3_0000, 48'h77);
    step(16);
    chk("lit_to_before", timeout_err, 0);
    step(1);
    chk("lit_to_at", timeout_err, TO_ON);
    step(3);
    r_beat(a5, 2'b00, 1);
    step(2);
    chk("lit_to_sticky", timeout_err, TO_ON);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hawk_axi_rd_master.md
Name: hawk_axi_rd_master

Overview:
- AXI4 read master for the HAWK chipset block; read-side counterpart of the page-write AXI master.
- Accepts 64B block read requests from HAWK managers (ATT/list/PPA fetch), issues single-beat AXI AR transactions and returns the 512-bit block with its request tag.
- Supports up to MAX_OUTSTANDING in-order reads, with a one-entry response skid buffer toward the manager.

Parameters:
- MAX_OUTSTANDING, 4: maximum ARs accepted but not yet answered on R; power of 2, minimum 2.
- AXI_ID, 0: constant ARID value; RID is not checked.
- TAG_W, 48: width of the request tag (ppa) carried alongside each read.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_addr  in  64  byte address of block; bits [5:0] ignored
- req_tag  in  TAG_W  tag returned with the data
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- resp_data  out  512  block data
- resp_tag  out  TAG_W  tag of the matching request
- resp_err  out  1  RRESP!=OKAY or RLAST==0 on the beat
- resp_valid  out  1  response valid
- resp_ready  in  1  manager accepts response
- m_axi_arid  out  4  =AXI_ID
- m_axi_araddr  out  64  {addr[63:6],6'b0}
- m_axi_arlen  out  8  constant 0
- m_axi_arsize  out  3  constant 3'd6
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rid  in  4  ignored
- m_axi_rdata  in  512
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- timeout_err  out  1  sticky watchdog flag; constant 0 when the optional feature is compiled out

Behaviour:
- Reset (async, rst=1): AR FSM=IDLE, outstanding count=0, tag FIFO empty, skid buffer empty.
- Reset output values: arvalid=0, araddr=0, req_ready=0, resp_valid=0, resp_data=0, resp_tag=0, resp_err=0, rready=0, timeout_err=0.
- Reset mid-transaction drops all in-flight state. The interconnect must be reset together with this block.
- AR FSM, IDLE:
  - req_ready = (count<MAX_OUTSTANDING) && !fifo_full.
  - On req_valid&&req_ready: latch the address, push req_tag into the tag FIFO, go to ADDR.
- AR FSM, ADDR:
  - arvalid=1; araddr stays stable until arready.
  - On arready: count+1, return to IDLE. req_ready=0 while in ADDR.
- Request-to-AR latency: 1 cycle (arvalid asserts the cycle after acceptance).
- R channel:
  - rready = !skid_full || resp_ready.
  - On rvalid&&rready: pop the tag FIFO; load resp_data/resp_tag/resp_err into the skid register; count-1.
  - resp_err = (rresp!=2'b00) || !rlast.
- resp_valid=1 while the skid register is full.
  - resp_ready with no new beat: skid empties.
  - resp_ready with a new beat in the same cycle: skid reloads and resp_valid stays 1.
- R-to-resp latency: 1 cycle.
- AR handshake and R handshake in the same cycle: count unchanged.
- Count==MAX_OUTSTANDING: req_ready=0 until an R beat retires.
- Tag FIFO depth = MAX_OUTSTANDING. Pointers have log2(MAX_OUTSTANDING) bits and wrap naturally. Full and empty are distinguished by an occupancy counter.
- An R beat while count==0 is a protocol violation: ignored, rready=0.
- Responses return strictly in request order; a single ID guarantees AXI ordering.

Optional Feature:
- Macro: HAWK_RD_TIMEOUT_EN.
- Enabled:
  - Counter increments each cycle while count>0 and no R handshake occurs; it clears on any R handshake or when count==0.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set. It is sticky until rst.
  - The datapath itself is unaffected.
- Disabled: no counter logic; timeout_err tied to 0.

Decomposition:
- hacd_pkg additions:
  - axi_rd_reqpkt_t {addr[63:0], tag[47:0], arvalid}
  - axi_rd_rdypkt_t {arready}
  - axi_rd_resppkt_t {data[511:0], tag[47:0], err, rvalid}
  - Constants AXI_SIZE_64B=3'd6, AXI_BURST_INCR=2'b01, HAWK_RD_MAX_OUTSTANDING=4.
  - Reuses BLK_SIZE.
- Sub-module hawk_rd_tag_fifo: synchronous FIFO, parameters DEPTH and WIDTH; ports push/pop/full/empty/wdata/rdata; async active-high reset.

Test Plan:
- Single read: req_addr=64'hFFF6100000 with bits[5:0]=6'h3F, tag=48'h1234 -> araddr=64'hFFF6100000, arlen=0, arsize=6. R beat rdata=512'hA5..A5, rresp=0, rlast=1 -> next cycle resp_valid=1, resp_data=A5..A5, resp_tag=48'h1234, resp_err=0.
- Back-pressure: 5 back-to-back requests with arready held 0 -> exactly one AR pending, req_ready=0. Release arready with R stalled -> count saturates at 4 and the 5th request is held until the first R beat.
- Ordering and skid: 4 reads with tags 1..4, resp_ready toggling 0/1 -> tags returned 1,2,3,4 with no drops or duplicates. rready drops only while the skid is full and resp_ready=0.
- Error beat: rresp=2'b10 -> resp_err=1. rresp=0 with rlast=0 -> resp_err=1. The next good beat has resp_err=0.
- Reset mid-op: assert rst with 3 reads outstanding and the skid full -> all outputs go to reset values immediately, asynchronously. After release, a new read completes normally with count starting at 0.
- With HAWK_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16: one AR issued, no R -> timeout_err=1 on the 16th cycle, still 1 after a later R beat. Same stimulus without the macro -> timeout_err stays 0.
